// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: upstream driver for a 3-to-8 decoder.
// Walks the channels enabled in a latched mask, lowest index first. Each channel is
// held for a programmable dwell, followed by one break-before-make gap cycle.
// Supports single-pass and continuous scanning, stop/start control, a pass-complete
// pulse and an error pulse for an empty mask.
// Optional feature: define SCAN_PASS_CNT_EN to add the saturating pass_cnt output.
module decoder_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    localparam int NCH    = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel_code,
    output logic               sel_en,
    output logic               busy,
    output logic               pass_done,
    output logic               err
`ifdef SCAN_PASS_CNT_EN
    ,
    output logic [7:0]         pass_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [NCH-1:0]     mask_q, mask_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic               cont_q, cont_n;
    logic [SEL_W-1:0]   code_n;
    logic               en_n, busy_n, pd_n, err_n;
    logic               has_next;
    logic [SEL_W-1:0]   next_ch;
    logic               dwell_term;

    // Lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] first_set(input logic [NCH-1:0] m);
        logic [SEL_W-1:0] r;
        logic             f;
        r = '0;
        f = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i] && !f) begin
                r = SEL_W'(i);
                f = 1'b1;
            end
        end
        return r;
    endfunction

    // Search for the lowest latched-mask bit strictly above the current channel.
    always_comb begin
        has_next = 1'b0;
        next_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!has_next && mask_q[i] && (i > int'(sel_code))) begin
                has_next = 1'b1;
                next_ch  = SEL_W'(i);
            end
        end
    end

    // A zero dwell behaves like a dwell of one cycle.
    assign dwell_term = (dwell_q <= DWELL_W'(1)) || (cnt == dwell_q - DWELL_W'(1));

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mask_n  = mask_q;
        dwell_n = dwell_q;
        cont_n  = cont_q;
        code_n  = sel_code;
        en_n    = 1'b0;
        busy_n  = busy;
        pd_n    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start && !stop) begin
                    if (mask != '0) begin
                        mask_n  = mask;
                        dwell_n = dwell;
                        cont_n  = cont;
                        code_n  = first_set(mask);
                        cnt_n   = '0;
                        en_n    = 1'b1;
                        busy_n  = 1'b1;
                        state_n = ACTIVE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (stop) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (dwell_term) begin
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    pd_n    = !has_next;
                    state_n = GAP;
                end else begin
                    cnt_n  = cnt + DWELL_W'(1);
                    en_n   = 1'b1;
                    busy_n = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (has_next) begin
                    code_n  = next_ch;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = ACTIVE;
                end else if (cont_q) begin
                    if (mask != '0) begin
                        mask_n  = mask;
                        dwell_n = dwell;
                        code_n  = first_set(mask);
                        en_n    = 1'b1;
                        busy_n  = 1'b1;
                        state_n = ACTIVE;
                    end else begin
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mask_q    <= '0;
            dwell_q   <= '0;
            cont_q    <= 1'b0;
            sel_code  <= '0;
            sel_en    <= 1'b0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mask_q    <= mask_n;
            dwell_q   <= dwell_n;
            cont_q    <= cont_n;
            sel_code  <= code_n;
            sel_en    <= en_n;
            busy      <= busy_n;
            pass_done <= pd_n;
            err       <= err_n;
        end
    end

`ifdef SCAN_PASS_CNT_EN
    // Saturating count of completed passes, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= 8'd0;
        end else if (state == IDLE && start && !stop && mask != '0) begin
            pass_cnt <= 8'd0;
        end else if (pd_n && pass_cnt != 8'd255) begin
            pass_cnt <= pass_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer (default build).
// Expected per-cycle output vectors {sel_code, sel_en, busy, pass_done, err} are queued
// as stimulus is applied and compared on the falling edge after each rising edge.
module tb_decoder_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel_code;
    logic       sel_en;
    logic       busy;
    logic       pass_done;
    logic       err;
`ifdef SCAN_PASS_CNT_EN
    logic [7:0] pass_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [6:0] exp_q[$];

    decoder_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .mask      (mask),
        .dwell     (dwell),
        .sel_code  (sel_code),
        .sel_en    (sel_en),
        .busy      (busy),
        .pass_done (pass_done),
        .err       (err)
`ifdef SCAN_PASS_CNT_EN
        ,
        .pass_cnt  (pass_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareVal(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] d, input logic c,
                                 input logic s, input logic p);
        mask  = m;
        dwell = d;
        cont  = c;
        start = s;
        stop  = p;
    endtask

    task automatic pushExp(input logic [2:0] code, input logic en, input logic bsy,
                           input logic pd, input logic er);
        exp_q.push_back({code, en, bsy, pd, er});
    endtask

    // Expected vectors for one complete pass over mask m with dwell d.
    task automatic pushPass(input logic [7:0] m, input logic [7:0] d);
        int dw;
        int last;
        dw   = (d == 8'd0) ? 1 : int'(d);
        last = 0;
        for (int i = 0; i < 8; i++) if (m[i]) last = i;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                for (int k = 0; k < dw; k++) pushExp(3'(i), 1'b1, 1'b1, 1'b0, 1'b0);
                pushExp(3'(i), 1'b0, 1'b1, (i == last), 1'b0);
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [6:0] expv;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=<none queued>", tag,
                   {sel_code, sel_en, busy, pass_done, err});
        end else begin
            expv = exp_q.pop_front();
            compareVal(tag, {sel_code, sel_en, busy, pass_done, err}, expv);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) checkOutput(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        compareVal("reset_state", {sel_code, sel_en, busy, pass_done, err}, 7'h00);
        rst_n = 1'b1;
        repeat (2) pushExp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("idle_after_reset");

        $display("[TB] test 1: single pass mask 25 dwell 3");
        applyStimulus(8'h25, 8'd3, 1'b0, 1'b1, 1'b0);
        pushPass(8'h25, 8'd3);
        repeat (2) pushExp(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_first");
        start = 1'b0;
        drain("t1_pass");

        $display("[TB] test 2: continuous mask 80 dwell 0");
        applyStimulus(8'h80, 8'd0, 1'b1, 1'b1, 1'b0);
        repeat (3) pushPass(8'h80, 8'd0);
        checkOutput("t2_first");
        start = 1'b0;
        drain("t2_cont");
        stop = 1'b1;
        pushExp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_stop_gap");
        stop = 1'b0;

        $display("[TB] test 3: stop during code 3");
        applyStimulus(8'hFF, 8'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (2) pushExp(3'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            pushExp(3'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        pushExp(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_first");
        start = 1'b0;
        drain("t3_scan");
        stop = 1'b1;
        pushExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_stop");
        stop = 1'b0;
        repeat (2) pushExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("t3_idle");

        $display("[TB] test 4: start with empty mask");
        applyStimulus(8'h00, 8'd2, 1'b0, 1'b1, 1'b0);
        pushExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_err");
        start = 1'b0;
        pushExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_after");

        $display("[TB] test 5: async reset mid-active");
        applyStimulus(8'h10, 8'd5, 1'b0, 1'b1, 1'b0);
        repeat (2) pushExp(3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_first");
        start = 1'b0;
        drain("t5_active");
        rst_n = 1'b0;
        #1;
        compareVal("t5_async_reset", {sel_code, sel_en, busy, pass_done, err}, 7'h00);
        @(negedge clk);
        compareVal("t5_reset_hold", {sel_code, sel_en, busy, pass_done, err}, 7'h00);
        rst_n = 1'b1;
        repeat (3) pushExp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("t5_no_activity");

        $display("[TB] test 6: mask change mid-pass with continuous scan");
        applyStimulus(8'h03, 8'd1, 1'b1, 1'b1, 1'b0);
        pushPass(8'h03, 8'd1);
        pushPass(8'h10, 8'd1);
        checkOutput("t6_first");
        start = 1'b0;
        mask  = 8'h10;
        drain("t6_passes");
        stop = 1'b1;
        pushExp(3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_stop");
        stop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
